// File: rtl/key_event_pkg.sv
// -----------------------------------------------------------------------------
// key_event_pkg
// Shared definitions for the key/switch debounce front end:
//   - rptState_e : per-channel auto-repeat FSM state encoding
//   - clog2w     : minimum counter width (at least 1 bit) for a value range
//   - maxOf      : larger of two elaboration-time values
// -----------------------------------------------------------------------------
package key_event_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rptState_e;

  // Smallest width w (>= 1) such that 2**w >= value, i.e. enough bits to
  // hold every count 0 .. value-1.
  function automatic int unsigned clog2w(input longint unsigned value);
    int unsigned w;
    w = 32'd63;
    for (int i = 63; i >= 1; i--) begin
      if ((64'd1 << i) >= value) begin
        w = unsigned'(i);
      end
    end
    return w;
  endfunction

  function automatic longint unsigned maxOf(input longint unsigned a,
                                            input longint unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_event_channel.sv
// -----------------------------------------------------------------------------
// key_event_channel
// One key channel: input synchroniser, hold-time debounce counter and an
// optional auto-repeat FSM. All outputs are registered.
// Ports:
//   iCLK     in   system clock
//   iRST_N   in   synchronous active-low reset
//   iKey     in   raw asynchronous key pin
//   oLevel   out  debounced level, 1 = pressed
//   oPress   out  one-cycle pulse when a press is accepted
//   oRelease out  one-cycle pulse when a release is accepted
//   oRepeat  out  one-cycle auto-repeat pulse while held (0 if REPEAT_EN=0)
// -----------------------------------------------------------------------------
module key_event_channel
  import key_event_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DB_CYCLES    = 500000,
  parameter int ACTIVE_LOW   = 1,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic iKey,
  output logic oLevel,
  output logic oPress,
  output logic oRelease,
  output logic oRepeat
);

  localparam int unsigned DB_W = clog2w(64'(DB_CYCLES) + 64'd1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  // Raw pin value that means "released"; also used to invert polarity.
  localparam logic RAW_IDLE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [SYNC_STAGES-1:0] SYNC_IDLE = {SYNC_STAGES{RAW_IDLE}};

  logic [SYNC_STAGES-1:0] syncChain_r;
  logic                   pressedSync_s;
  logic [DB_W-1:0]        dbCount_r;
  logic [DB_W-1:0]        dbCountNext_s;
  logic                   level_r;
  logic                   levelNext_s;
  logic                   press_r;
  logic                   pressNext_s;
  logic                   release_r;
  logic                   releaseNext_s;

  // Synchroniser chain; reset loads the released level so no edge is seen.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      syncChain_r <= SYNC_IDLE;
    end else begin
      syncChain_r <= {syncChain_r[SYNC_STAGES-2:0], iKey};
    end
  end

  assign pressedSync_s = syncChain_r[SYNC_STAGES-1] ^ RAW_IDLE;

  // Debounce next state: accept a new level only after DB_CYCLES agreeing samples.
  always_comb begin
    dbCountNext_s = dbCount_r;
    levelNext_s   = level_r;
    pressNext_s   = 1'b0;
    releaseNext_s = 1'b0;
    if (pressedSync_s == level_r) begin
      dbCountNext_s = {DB_W{1'b0}};
    end else if (dbCount_r == DB_LAST) begin
      dbCountNext_s = {DB_W{1'b0}};
      levelNext_s   = pressedSync_s;
      pressNext_s   = pressedSync_s;
      releaseNext_s = ~pressedSync_s;
    end else begin
      dbCountNext_s = dbCount_r + DB_W'(1);
    end
  end

  // Debounce state and registered level / edge pulses.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      dbCount_r <= {DB_W{1'b0}};
      level_r   <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      dbCount_r <= dbCountNext_s;
      level_r   <= levelNext_s;
      press_r   <= pressNext_s;
      release_r <= releaseNext_s;
    end
  end

  assign oLevel   = level_r;
  assign oPress   = press_r;
  assign oRelease = release_r;

  generate
    if (REPEAT_EN != 0) begin : gRepeat
      localparam int unsigned RPT_W =
        clog2w(maxOf(64'(REPEAT_DELAY), 64'(REPEAT_RATE)));
      localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
      localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

      rptState_e        state_r;
      rptState_e        stateNext_s;
      logic [RPT_W-1:0] timer_r;
      logic [RPT_W-1:0] timerNext_s;
      logic             repeat_r;
      logic             repeatNext_s;

      // Repeat FSM state, timer and registered repeat pulse.
      always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
          state_r  <= RPT_IDLE;
          timer_r  <= {RPT_W{1'b0}};
          repeat_r <= 1'b0;
        end else begin
          state_r  <= stateNext_s;
          timer_r  <= timerNext_s;
          repeat_r <= repeatNext_s;
        end
      end

      // Repeat FSM next state. Driven by the same-cycle accept strobes so
      // the timer starts on the press-pulse edge and a release cancels any
      // repeat falling due on its own edge.
      always_comb begin
        stateNext_s  = state_r;
        timerNext_s  = timer_r;
        repeatNext_s = 1'b0;
        if (releaseNext_s) begin
          stateNext_s = RPT_IDLE;
          timerNext_s = {RPT_W{1'b0}};
        end else begin
          case (state_r)
            RPT_IDLE: begin
              timerNext_s = {RPT_W{1'b0}};
              if (pressNext_s) begin
                stateNext_s = RPT_DELAY;
              end else begin
                stateNext_s = RPT_IDLE;
              end
            end
            RPT_DELAY: begin
              if (timer_r == DELAY_LAST) begin
                repeatNext_s = 1'b1;
                stateNext_s  = RPT_REPEAT;
                timerNext_s  = {RPT_W{1'b0}};
              end else begin
                timerNext_s = timer_r + RPT_W'(1);
              end
            end
            RPT_REPEAT: begin
              if (timer_r == RATE_LAST) begin
                repeatNext_s = 1'b1;
                timerNext_s  = {RPT_W{1'b0}};
              end else begin
                timerNext_s = timer_r + RPT_W'(1);
              end
            end
            default: begin
              stateNext_s = RPT_IDLE;
              timerNext_s = {RPT_W{1'b0}};
            end
          endcase
        end
      end

      assign oRepeat = repeat_r;
    end else begin : gNoRepeat
      assign oRepeat = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/key_event_debounce.sv
// -----------------------------------------------------------------------------
// key_event_debounce
// Multi-channel push-button front end: N_KEYS independent debounce channels
// plus an any-press summary.
// Ports:
//   iCLK      in   system clock
//   iRST_N    in   synchronous active-low reset
//   iKey      in   [N_KEYS] raw asynchronous key pins
//   oLevel    out  [N_KEYS] debounced levels, 1 = pressed
//   oPress    out  [N_KEYS] press-accepted pulses
//   oRelease  out  [N_KEYS] release-accepted pulses
//   oRepeat   out  [N_KEYS] auto-repeat pulses
//   oAnyPress out  OR of oPress (same timing as oPress)
// -----------------------------------------------------------------------------
module key_event_debounce
  import key_event_pkg::*;
#(
  parameter int N_KEYS       = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int DB_CYCLES    = 500000,
  parameter int ACTIVE_LOW   = 1,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic [N_KEYS-1:0] iKey,
  output logic [N_KEYS-1:0] oLevel,
  output logic [N_KEYS-1:0] oPress,
  output logic [N_KEYS-1:0] oRelease,
  output logic [N_KEYS-1:0] oRepeat,
  output logic              oAnyPress
);

  generate
    for (genvar k = 0; k < N_KEYS; k++) begin : gChan
      key_event_channel #(
        .SYNC_STAGES (SYNC_STAGES),
        .DB_CYCLES   (DB_CYCLES),
        .ACTIVE_LOW  (ACTIVE_LOW),
        .REPEAT_EN   (REPEAT_EN),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
      ) uChan (
        .iCLK    (iCLK),
        .iRST_N  (iRST_N),
        .iKey    (iKey[k]),
        .oLevel  (oLevel[k]),
        .oPress  (oPress[k]),
        .oRelease(oRelease[k]),
        .oRepeat (oRepeat[k])
      );
    end
  endgenerate

  // Built from the registered press bits, so it adds no cycle of latency.
  assign oAnyPress = |oPress;

endmodule

// File: tb/tb_key_event_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_event_debounce
// Two instances: main (DB_CYCLES=4, repeat enabled) and alt (DB_CYCLES=1,
// repeat disabled). Stimulus tasks push expected pulse events (edge number,
// instance, channel, kind) into a queue; a monitor pops the events due on
// each edge and compares every output of both instances on every edge.
// -----------------------------------------------------------------------------
module tb_key_event_debounce;

  localparam int SYNC   = 2;
  localparam int RDELAY = 10;
  localparam int RRATE  = 3;
  localparam int LAT0   = SYNC + 4;   // main instance: press at edge LAT0 after edge 1
  localparam int LAT1   = SYNC + 1;   // alt instance

  typedef struct {
    int edgeNo;
    int dut;
    int ch;
    int kind;   // 0 press, 1 release, 2 repeat
  } ev_t;

  logic       iCLK;
  logic       iRST_N;
  logic [3:0] key;
  logic [3:0] keyB;
  logic [3:0] level0, press0, release0, repeat0;
  logic       any0;
  logic [3:0] level1, press1, release1, repeat1;
  logic       any1;

  ev_t        sbQ[$];
  int         edgeCnt  = 0;
  int         checks   = 0;
  int         failures = 0;
  logic       rstSeen;
  logic [3:0] levelExp[2] = '{4'd0, 4'd0};

  key_event_debounce #(
    .N_KEYS(4), .SYNC_STAGES(SYNC), .DB_CYCLES(4), .ACTIVE_LOW(1),
    .REPEAT_EN(1), .REPEAT_DELAY(RDELAY), .REPEAT_RATE(RRATE)
  ) dut0 (
    .iCLK(iCLK), .iRST_N(iRST_N), .iKey(key),
    .oLevel(level0), .oPress(press0), .oRelease(release0),
    .oRepeat(repeat0), .oAnyPress(any0)
  );

  key_event_debounce #(
    .N_KEYS(4), .SYNC_STAGES(SYNC), .DB_CYCLES(1), .ACTIVE_LOW(1),
    .REPEAT_EN(0), .REPEAT_DELAY(RDELAY), .REPEAT_RATE(RRATE)
  ) dut1 (
    .iCLK(iCLK), .iRST_N(iRST_N), .iKey(keyB),
    .oLevel(level1), .oPress(press1), .oRelease(release1),
    .oRepeat(repeat1), .oAnyPress(any1)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic checkVal(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, edgeCnt, act, exp);
    end
  endtask

  task automatic pushEv(input int edgeNo, input int dut, input int ch,
                        input int kind);
    ev_t ev;
    ev = '{edgeNo: edgeNo, dut: dut, ch: ch, kind: kind};
    sbQ.push_back(ev);
  endtask

  // Hold the keys in mask low for 'hold' sampled cycles, then release and
  // let the release settle. Expected events follow the documented timing:
  // press at first-sample + latency, repeats every RRATE after RDELAY,
  // release at first-high-sample + latency, and no repeat on or after it.
  task automatic pressMask(input int dut, input logic [3:0] mask,
                           input int hold);
    int e, lat, p, rel;
    @(negedge iCLK);
    e   = edgeCnt + 1;
    lat = (dut == 0) ? LAT0 - 1 : LAT1 - 1;
    if (dut == 0) key = key & ~mask;
    else          keyB = keyB & ~mask;
    p   = e + lat;
    rel = e + hold + lat;
    for (int ch = 0; ch < 4; ch++) begin
      if (mask[ch]) begin
        pushEv(p, dut, ch, 0);
        pushEv(rel, dut, ch, 1);
        if (dut == 0) begin
          for (int t = p + RDELAY; t < rel; t += RRATE) pushEv(t, dut, ch, 2);
        end
      end
    end
    repeat (hold) @(negedge iCLK);
    if (dut == 0) key = key | mask;
    else          keyB = keyB | mask;
    repeat (lat + 3) @(negedge iCLK);
  endtask

  // Monitor: pop the events due on this edge and compare all outputs.
  always begin
    logic [3:0] expP[2];
    logic [3:0] expR[2];
    logic [3:0] expT[2];
    @(posedge iCLK);
    edgeCnt = edgeCnt + 1;
    rstSeen = ~iRST_N;
    #1;
    for (int d = 0; d < 2; d++) begin
      expP[d] = 4'd0;
      expR[d] = 4'd0;
      expT[d] = 4'd0;
    end
    for (int i = sbQ.size() - 1; i >= 0; i--) begin
      if (sbQ[i].edgeNo == edgeCnt) begin
        case (sbQ[i].kind)
          0:       expP[sbQ[i].dut][sbQ[i].ch] = 1'b1;
          1:       expR[sbQ[i].dut][sbQ[i].ch] = 1'b1;
          default: expT[sbQ[i].dut][sbQ[i].ch] = 1'b1;
        endcase
        sbQ.delete(i);
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (rstSeen) begin
        expP[d] = 4'd0;
        expR[d] = 4'd0;
        expT[d] = 4'd0;
        levelExp[d] = 4'd0;
      end else begin
        levelExp[d] = (levelExp[d] | expP[d]) & ~expR[d];
      end
    end
    checkVal("press",      32'(press0),   32'(expP[0]));
    checkVal("release",    32'(release0), 32'(expR[0]));
    checkVal("repeat",     32'(repeat0),  32'(expT[0]));
    checkVal("level",      32'(level0),   32'(levelExp[0]));
    checkVal("anyPress",   32'(any0),     32'(|expP[0]));
    checkVal("altPress",   32'(press1),   32'(expP[1]));
    checkVal("altRelease", 32'(release1), 32'(expR[1]));
    checkVal("altRepeat",  32'(repeat1),  32'(4'd0));
    checkVal("altLevel",   32'(level1),   32'(levelExp[1]));
    checkVal("altAny",     32'(any1),     32'(|expP[1]));
  end

  initial begin
    int e, rs;
    key    = 4'hF;
    keyB   = 4'hF;
    iRST_N = 1'b0;
    repeat (3) @(negedge iCLK);
    iRST_N = 1'b1;
    repeat (4) @(negedge iCLK);

    // Clean press / release on channel 0 (released before first repeat).
    pressMask(0, 4'b0001, 8);

    // Bounce on channel 1: 3-cycle pulses never accepted, then a clean hold.
    for (int k = 0; k < 5; k++) begin
      @(negedge iCLK);
      key[1] = 1'b0;
      repeat (3) @(negedge iCLK);
      key[1] = 1'b1;
      repeat (2) @(negedge iCLK);
    end
    pressMask(0, 4'b0010, 8);

    // Auto-repeat on channel 2: release accepted exactly when a repeat is due.
    pressMask(0, 4'b0100, 25);
    // Longer hold: repeats continue at the repeat rate until release.
    pressMask(0, 4'b0100, 30);

    // Simultaneous press on channels 0 and 3.
    pressMask(0, 4'b1001, 6);

    // Reset while held: clears with no release, then press is re-accepted.
    @(negedge iCLK);
    e = edgeCnt + 1;
    key[0] = 1'b0;
    pushEv(e + LAT0 - 1, 0, 0, 0);
    repeat (7) @(negedge iCLK);
    iRST_N = 1'b0;
    rs = edgeCnt + 1;
    @(negedge iCLK);
    iRST_N = 1'b1;
    pushEv(rs + LAT0, 0, 0, 0);
    repeat (6) @(negedge iCLK);
    key[0] = 1'b1;
    pushEv(edgeCnt + 1 + LAT0 - 1, 0, 0, 1);
    repeat (8) @(negedge iCLK);

    // Alt instance: minimum debounce, no repeat logic, long hold.
    pressMask(1, 4'b0001, 40);

    repeat (5) @(negedge iCLK);
    checkVal("sbEmpty", 32'(sbQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
